// File: rtl/dac_write_sched.sv
// dac_write_sched: round-robin scheduler sharing one serial DAC write engine between NUM_CH controllers.
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   enable               scheduler enable; low flushes pending requests and blocks new writes
//   ch_ready, ch_data    per-channel ready level (rising edge = request) and 16-bit command
//   ch_busy              per-channel pending-or-in-flight flag
//   dac_start/chan/data  one-clock launch pulse plus channel and value held until dac_done
//   dac_done             completion pulse from the serializer
//   overrun_cnt          per-channel 8-bit saturating count of overwritten pending requests
//   timeout_err          sticky write-timeout flag
module dac_write_sched #(
    parameter int NUM_CH  = 4,
    parameter int TIMEOUT = 512,
    parameter int GAP     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [NUM_CH-1:0]     ch_ready,
    input  logic [16*NUM_CH-1:0]  ch_data,
    output logic [NUM_CH-1:0]     ch_busy,
    output logic                  dac_start,
    output logic [2:0]            dac_chan,
    output logic [15:0]           dac_data,
    input  logic                  dac_done,
    output logic [8*NUM_CH-1:0]   overrun_cnt,
    output logic                  timeout_err
);
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam int GW = $clog2(GAP + 1) + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

    state_t               state;
    logic [NUM_CH-1:0]    ready_s, ready_q, req, pend, pend_nxt, issue_clr, inflight_nxt;
    logic [16*NUM_CH-1:0] pend_data;
    logic [2:0]           sel, rr_ptr, cand;
    logic [15:0]          cand_data;
    logic [TW-1:0]        timer;
    logic [GW-1:0]        gcnt;
    logic                 go, done_w, expire;
    int                   j;

    // Scan from rr_ptr+NUM_CH down to rr_ptr+1 so the last hit is the first in priority order.
    always_comb begin
        cand = '0;
        j = 0;
        for (int k = NUM_CH; k >= 1; k--) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_CH) j = j - NUM_CH;
            if (|(pend & (NUM_CH'(1) << j))) cand = 3'(j);
        end
    end

    assign req       = ready_s & ~ready_q;
    assign go        = (state == S_IDLE) && enable && (|pend);
    assign done_w    = (state == S_WAIT) && dac_done;
    assign expire    = (state == S_WAIT) && !dac_done && (timer == TW'(TIMEOUT - 1));
    assign issue_clr = (state == S_ISSUE) ? (NUM_CH'(1) << sel) : '0;
    assign pend_nxt  = enable ? ((pend & ~issue_clr) | req) : '0;
    // A capture landing on the launch edge is the newest data, so issue it directly.
    assign cand_data = (enable && |(req & (NUM_CH'(1) << cand))) ? ch_data[16*cand +: 16]
                                                                 : pend_data[16*cand +: 16];
    assign inflight_nxt = go ? (NUM_CH'(1) << cand) :
                          ((state == S_ISSUE) || ((state == S_WAIT) && !done_w && !expire)) ? (NUM_CH'(1) << sel) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            ready_s     <= '0;
            ready_q     <= '0;
            pend        <= '0;
            pend_data   <= '0;
            overrun_cnt <= '0;
            ch_busy     <= '0;
            sel         <= '0;
            rr_ptr      <= 3'(NUM_CH - 1);
            timer       <= '0;
            gcnt        <= '0;
            dac_start   <= 1'b0;
            dac_chan    <= '0;
            dac_data    <= '0;
            timeout_err <= 1'b0;
        end else begin
            ready_s <= ch_ready;
            ready_q <= ready_s;
            pend    <= pend_nxt;
            ch_busy <= pend_nxt | inflight_nxt;
            for (int i = 0; i < NUM_CH; i++) begin
                if (enable && req[i]) begin
                    pend_data[16*i +: 16] <= ch_data[16*i +: 16];
                    // Re-request of the channel being issued is a fresh capture, not an overrun.
                    if (pend[i] && !issue_clr[i] && overrun_cnt[8*i +: 8] != 8'hFF)
                        overrun_cnt[8*i +: 8] <= overrun_cnt[8*i +: 8] + 8'd1;
                end
            end
            case (state)
                S_IDLE: begin
                    if (go) begin
                        state     <= S_ISSUE;
                        sel       <= cand;
                        dac_start <= 1'b1;
                        dac_chan  <= cand;
                        dac_data  <= cand_data;
                        timer     <= '0;
                    end
                end
                S_ISSUE: begin
                    dac_start <= 1'b0;
                    rr_ptr    <= sel;
                    timer     <= timer + TW'(1);
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    timer <= timer + TW'(1);
                    if (done_w || expire) begin
                        state    <= S_GAP;
                        gcnt     <= '0;
                        dac_chan <= '0;
                        dac_data <= '0;
                    end
                    if (expire) timeout_err <= 1'b1;
                end
                default: begin
                    if (gcnt == GW'(GAP - 1)) state <= S_IDLE;
                    else gcnt <= gcnt + GW'(1);
                end
            endcase
        end
    end
endmodule
